// File: rtl/ldl_dff_array_flow_ctrl_if.sv
// Handshake bundle between a DFF-array flow controller and its upstream/downstream neighbours.
// The controller side uses the slave modport; the environment driving it uses master.
interface ldl_dff_array_flow_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic flush;
  logic flush_done;

  modport master (
    output in_valid,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  flush_done
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output flush_done
  );
endinterface

// File: rtl/ldl_dff_array_flow_ctrl.sv
// Valid/ready controller for a LEVEL-stage globally-enabled DFF shift array: owns the array
// enable, tracks per-stage valid bits and occupancy, and runs a flush/drain sequence.
module ldl_dff_array_flow_ctrl #(
  parameter int unsigned LEVEL = 4,
  localparam int unsigned CNT_W = $clog2(LEVEL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  ldl_dff_array_flow_ctrl_if.slave hs,
  output logic                 shift_en,
  output logic [LEVEL-1:0]     stage_vld,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 busy
);

  typedef enum logic {StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [LEVEL-1:0]   stage_vld_q, stage_vld_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               flush_done_q, flush_done_d;

  logic out_valid, advance, accept, pop, in_ready;
  logic [LEVEL-1:0]   shifted;

  assign out_valid = stage_vld_q[LEVEL-1];
  assign advance   = !out_valid || hs.out_ready;
  assign in_ready  = advance && (state_q == StRun);
  assign accept    = hs.in_valid && in_ready;
  assign pop       = out_valid && hs.out_ready;
  // Hold the array enable low when there is nothing to move, so an idle pipe never toggles.
  assign shift_en  = advance && ((|stage_vld_q) || accept);

  generate
    if (LEVEL == 1) begin : g_single
      assign shifted = accept;
    end else begin : g_multi
      assign shifted = {stage_vld_q[LEVEL-2:0], accept};
    end
  endgenerate

  always_comb begin
    stage_vld_d  = stage_vld_q;
    occ_d        = occ_q + CNT_W'(accept) - CNT_W'(pop);
    state_d      = state_q;
    flush_done_d = 1'b0;
    if (shift_en) begin
      stage_vld_d = shifted;
    end
    unique case (state_q)
      StRun: begin
        if (hs.flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (stage_vld_d == '0) begin
          state_d      = StRun;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      stage_vld_q  <= '0;
      occ_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_vld_q  <= stage_vld_d;
      occ_q        <= occ_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign hs.in_ready   = in_ready;
  assign hs.out_valid  = out_valid;
  assign hs.flush_done = flush_done_q;
  assign stage_vld     = stage_vld_q;
  assign occupancy     = occ_q;
  assign busy          = (occ_q != '0) || (state_q == StDrain);

endmodule

// File: tb/tb_ldl_dff_array_flow_ctrl.sv
// Directed bench for the DFF-array flow controller at LEVEL=4 and LEVEL=1, each paired with
// a bench-side data array clocked by the controller's shift_en.
module tb_ldl_dff_array_flow_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldl_dff_array_flow_ctrl_if hs4 ();
  ldl_dff_array_flow_ctrl_if hs1 ();

  logic       shift_en4, busy4, shift_en1, busy1;
  logic [3:0] stage_vld4;
  logic [2:0] occupancy4;
  logic [0:0] stage_vld1;
  logic [0:0] occupancy1;

  ldl_dff_array_flow_ctrl #(.LEVEL(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs4.slave),
    .shift_en  (shift_en4),
    .stage_vld (stage_vld4),
    .occupancy (occupancy4),
    .busy      (busy4)
  );

  ldl_dff_array_flow_ctrl #(.LEVEL(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs1.slave),
    .shift_en  (shift_en1),
    .stage_vld (stage_vld1),
    .occupancy (occupancy1),
    .busy      (busy1)
  );

  // Bench-side data arrays enabled by the controller.
  logic [7:0] din4, din1, arr1;
  logic [7:0] arr4 [4];
  always @(posedge clk) begin
    if (shift_en4) begin
      arr4[3] <= arr4[2];
      arr4[2] <= arr4[1];
      arr4[1] <= arr4[0];
      arr4[0] <= din4;
    end
    if (shift_en1) arr1 <= din1;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Occupancy must always match the number of valid stages.
  always @(negedge clk) begin
    if (!rst) begin
      check("occ_pop4", 32'(occupancy4), 32'($countones(stage_vld4)));
      check("occ_pop1", 32'(occupancy1), 32'($countones(stage_vld1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hs4.in_valid = 1'b0; hs4.out_ready = 1'b0; hs4.flush = 1'b0; din4 = 8'h00;
    hs1.in_valid = 1'b0; hs1.out_ready = 1'b0; hs1.flush = 1'b0; din1 = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_stage_vld", 32'(stage_vld4), 32'h0);
    check("rst_occ", 32'(occupancy4), 32'h0);
    check("rst_out_valid", 32'(hs4.out_valid), 32'h0);
    check("rst_shift_en", 32'(shift_en4), 32'h0);
    check("rst_flush_done", 32'(hs4.flush_done), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_in_ready", 32'(hs4.in_ready), 32'h1);
    check("rst_in_ready1", 32'(hs1.in_ready), 32'h1);
    tick();
  endtask

  initial begin
    int acc, pp;
    do_reset();

    // 1: streaming, out_ready held high
    for (int k = 0; k < 12; k++) begin
      hs4.in_valid = (k < 6); din4 = 8'(k + 1); hs4.out_ready = 1'b1;
      @(negedge clk);
      acc = (k < 6) ? k : 6;
      pp  = (k < 4) ? 0 : ((k - 4 > 6) ? 6 : k - 4);
      check("t1_in_ready", 32'(hs4.in_ready), 32'h1);
      check("t1_out_valid", 32'(hs4.out_valid), 32'((k >= 4) && (k <= 9)));
      check("t1_occ", 32'(occupancy4), 32'(acc - pp));
      if (k >= 4 && k <= 9) check("t1_dout", 32'(arr4[3]), 32'(k - 3));
      tick();
    end

    // 2: fill then backpressure
    do_reset();
    for (int k = 0; k < 14; k++) begin
      hs4.in_valid = (k < 4); din4 = 8'(11 + k); hs4.out_ready = (k >= 9);
      @(negedge clk);
      if (k >= 4 && k <= 8) begin
        check("t2_in_ready", 32'(hs4.in_ready), 32'h0);
        check("t2_shift_en", 32'(shift_en4), 32'h0);
        check("t2_occ", 32'(occupancy4), 32'h4);
        check("t2_dout_hold", 32'(arr4[3]), 32'd11);
      end
      if (k >= 9 && k <= 12) begin
        check("t2_out_valid", 32'(hs4.out_valid), 32'h1);
        check("t2_dout", 32'(arr4[3]), 32'(11 + k - 9));
      end
      if (k == 13) check("t2_empty", 32'(occupancy4), 32'h0);
      tick();
    end

    // 3: bubbles travel with the data
    do_reset();
    for (int k = 0; k < 8; k++) begin
      hs4.in_valid = (k == 0) || (k == 2); din4 = 8'(21 + k); hs4.out_ready = 1'b1;
      @(negedge clk);
      case (k)
        1: check("t3_vld1", 32'(stage_vld4), 32'h1);
        2: check("t3_vld2", 32'(stage_vld4), 32'h2);
        3: check("t3_vld3", 32'(stage_vld4), 32'h5);
        4: check("t3_vld4", 32'(stage_vld4), 32'ha);
        default: ;
      endcase
      if (k >= 4) check("t3_out_valid", 32'(hs4.out_valid), 32'(k == 4 || k == 6));
      if (k == 4) check("t3_dout_a", 32'(arr4[3]), 32'd21);
      if (k == 6) check("t3_dout_b", 32'(arr4[3]), 32'd23);
      tick();
    end

    // 4: flush with a same-cycle accept, then drain
    do_reset();
    for (int k = 0; k < 10; k++) begin
      hs4.in_valid = (k <= 4); din4 = (k <= 3) ? 8'(31 + k) : 8'h99;
      hs4.flush = (k == 3); hs4.out_ready = (k >= 4);
      @(negedge clk);
      if (k == 3) check("t4_accept", 32'(hs4.in_ready), 32'h1);
      if (k >= 4 && k <= 7) begin
        check("t4_in_ready", 32'(hs4.in_ready), 32'h0);
        check("t4_out_valid", 32'(hs4.out_valid), 32'h1);
        check("t4_dout", 32'(arr4[3]), 32'(31 + k - 4));
        check("t4_busy", 32'(busy4), 32'h1);
      end
      if (k >= 4) check("t4_flush_done", 32'(hs4.flush_done), 32'(k == 8));
      if (k == 8) begin
        check("t4_ready_back", 32'(hs4.in_ready), 32'h1);
        check("t4_idle", 32'(busy4), 32'h0);
      end
      tick();
    end

    // 5: idle empty pipe never shifts; flush while empty
    do_reset();
    for (int k = 0; k < 10; k++) begin
      hs4.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t5_no_shift", 32'(shift_en4), 32'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      hs4.flush = (k == 0);
      @(negedge clk);
      check("t5_flush_done", 32'(hs4.flush_done), 32'(k == 2));
      if (k == 1) check("t5_drain_busy", 32'(busy4), 32'h1);
      if (k == 1) check("t5_drain_ready", 32'(hs4.in_ready), 32'h0);
      tick();
    end

    // 6: reset in the middle of a drain
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hs4.in_valid = (k < 2); din4 = 8'(51 + k); hs4.flush = (k == 2);
      tick();
    end
    hs4.in_valid = 1'b0; hs4.flush = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t6_pre_occ", 32'(occupancy4), 32'h2);
    check("t6_pre_busy", 32'(busy4), 32'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_vld", 32'(stage_vld4), 32'h0);
    check("t6_occ", 32'(occupancy4), 32'h0);
    check("t6_run", 32'(hs4.in_ready), 32'h1);
    check("t6_no_done", 32'(hs4.flush_done), 32'h0);
    tick();
    @(negedge clk);
    check("t6_no_done2", 32'(hs4.flush_done), 32'h0);
    tick();

    // LEVEL=1: latency 1 and backpressure
    do_reset();
    for (int k = 0; k < 5; k++) begin
      hs1.in_valid = (k <= 2); din1 = (k == 0) ? 8'd41 : 8'd42; hs1.out_ready = (k != 1);
      @(negedge clk);
      check("l1_out_valid", 32'(hs1.out_valid), 32'(k >= 1 && k <= 3));
      if (k == 1) check("l1_stall_ready", 32'(hs1.in_ready), 32'h0);
      if (k == 1 || k == 2) check("l1_dout_a", 32'(arr1), 32'd41);
      if (k == 3) check("l1_dout_b", 32'(arr1), 32'd42);
      if (k == 2) check("l1_ready", 32'(hs1.in_ready), 32'h1);
      if (k == 2) hs1.in_valid = 1'b1;
      tick();
      if (k == 2) hs1.in_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
